// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Scan scheduler for a 4-digit multiplexed seven-segment display that
//   shares one BCD-to-7-segment decoder across four active-low digit enables.
//   Each digit slot lasts DIV clocks. The first DEAD clocks of every slot keep
//   all digits off to avoid ghosting. New values are written through a
//   valid/ready port into a shadow buffer. That buffer is copied to the
//   displayed (active) value only at frame boundaries.
//
// Ports
//   Clk        in   system clock, rising edge
//   Aclr       in   asynchronous reset, active-low
//   en         in   scan enable; low = display dark, counters held at 0
//   lzb        in   leading-zero blanking enable
//   wr_valid   in   write request
//   wr_data    in   four BCD digits, [3:0] = rightmost digit (COM_1)
//   wr_ready   out  shadow buffer empty, a write would be accepted
//   com_n      out  active-low one-hot digit enables, bit k drives COM_(k+1)
//   bcd        out  BCD code to the decoder
//   bi_n       out  decoder blanking input, low = segments blank
//   frame_tick out  one-cycle pulse on the last cycle of the digit3 slot
module seg_scan_ctrl #(
  parameter int DIV  = 1000,
  parameter int DEAD = 2,
  parameter int CW   = 16
) (
  input  logic        Clk,
  input  logic        Aclr,
  input  logic        en,
  input  logic        lzb,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  output logic [3:0]  com_n,
  output logic [3:0]  bcd,
  output logic        bi_n,
  output logic        frame_tick
);

  logic [CW-1:0] s_q, s_d;
  logic [1:0]    k_q, k_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          rdy_q, rdy_d;
  logic [3:0]    com_q, com_d;
  logic [3:0]    bcd_q, bcd_d;
  logic          bi_q, bi_d;
  logic          ft_q, ft_d;
  logic          wrap, bnd, acc;

  function automatic logic [3:0] digit_sel(input logic [15:0] a, input logic [1:0] k);
    logic [3:0] d;
    case (k)
      2'd0:    d = a[3:0];
      2'd1:    d = a[7:4];
      2'd2:    d = a[11:8];
      default: d = a[15:12];
    endcase
    return d;
  endfunction

  // A digit is blanked when it and every more significant digit are zero.
  // The rightmost digit always shows, so a value of zero displays as "0".
  function automatic logic blank_sel(input logic [15:0] a, input logic [1:0] k,
                                     input logic lz);
    logic b;
    case (k)
      2'd0:    b = 1'b0;
      2'd1:    b = (a[15:4] == 12'd0);
      2'd2:    b = (a[15:8] == 8'd0);
      default: b = (a[15:12] == 4'd0);
    endcase
    return b & lz;
  endfunction

  always_comb begin
    wrap     = (s_q == CW'(DIV - 1));
    bnd      = en && wrap && (k_q == 2'd3);
    acc      = wr_valid && rdy_q;
    s_d      = '0;
    k_d      = 2'd0;
    active_d = active_q;
    shadow_d = shadow_q;
    rdy_d    = rdy_q;

    if (en) begin
      s_d = wrap ? '0 : s_q + 1'b1;
      k_d = wrap ? k_q + 2'd1 : k_q;
    end

    // The shadow empties on a boundary before a write can refill it. A write
    // that lands on the same edge as a boundary with an empty shadow only
    // fills the shadow.
    if (bnd && !rdy_q) begin
      active_d = shadow_q;
      rdy_d    = 1'b1;
    end
    if (acc) begin
      shadow_d = wr_data;
      rdy_d    = 1'b0;
    end

    // Output flops are loaded with the view of the next cycle. The pins then
    // show the slot state of the current cycle directly from registers.
    com_d = 4'b1111;
    bi_d  = 1'b0;
    bcd_d = en ? digit_sel(active_d, k_d) : 4'd0;
    if (en && (s_d >= CW'(DEAD))) begin
      com_d = ~(4'b0001 << k_d);
      bi_d  = ~blank_sel(active_d, k_d, lzb);
    end
    ft_d = en && (k_d == 2'd3) && (s_d == CW'(DIV - 1));
  end

  always_ff @(posedge Clk or negedge Aclr) begin
    if (!Aclr) begin
      s_q      <= '0;
      k_q      <= 2'd0;
      active_q <= 16'd0;
      shadow_q <= 16'd0;
      rdy_q    <= 1'b1;
      com_q    <= 4'b1111;
      bcd_q    <= 4'd0;
      bi_q     <= 1'b0;
      ft_q     <= 1'b0;
    end else begin
      s_q      <= s_d;
      k_q      <= k_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      rdy_q    <= rdy_d;
      com_q    <= com_d;
      bcd_q    <= bcd_d;
      bi_q     <= bi_d;
      ft_q     <= ft_d;
    end
  end

  assign wr_ready   = rdy_q;
  assign com_n      = com_q;
  assign bcd        = bcd_q;
  assign bi_n       = bi_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int DIV  = 8;
  localparam int DEAD = 2;
  localparam int CW   = 16;

  logic        Clk;
  logic        Aclr;
  logic        en;
  logic        lzb;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [3:0]  com_n;
  logic [3:0]  bcd;
  logic        bi_n;
  logic        frame_tick;

  seg_scan_ctrl #(.DIV(DIV), .DEAD(DEAD), .CW(CW)) dut (
    .Clk       (Clk),
    .Aclr      (Aclr),
    .en        (en),
    .lzb       (lzb),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .com_n     (com_n),
    .bcd       (bcd),
    .bi_n      (bi_n),
    .frame_tick(frame_tick)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] com;
    logic [3:0] bcd;
    logic       chk;
    logic       bi;
    logic       ft;
    logic       rdy;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   tk    = 0;
  int   ts    = 0;
  string phase = "init";
  logic done = 1'b0;

  // Monitor: every cycle the DUT presents one output vector, compared mid-cycle.
  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total = total + 1;
      if (com_n !== e.com || bi_n !== e.bi || frame_tick !== e.ft ||
          wr_ready !== e.rdy || (e.chk && bcd !== e.bcd)) begin
        bad = bad + 1;
        $display("FAIL %s: got com_n=%b bcd=%h bi_n=%b ft=%b rdy=%b, want com_n=%b bcd=%h(chk=%b) bi_n=%b ft=%b rdy=%b",
                 e.nm, com_n, bcd, bi_n, frame_tick, wr_ready,
                 e.com, e.bcd, e.chk, e.bi, e.ft, e.rdy);
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      bad = bad + 1;
      $display("FAIL timeout: stimulus did not complete, phase=%s", phase);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic check_reset(input string nm);
    total = total + 1;
    if (com_n !== 4'b1111 || bcd !== 4'd0 || bi_n !== 1'b0 ||
        frame_tick !== 1'b0 || wr_ready !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL %s: reset state got com_n=%b bcd=%h bi_n=%b ft=%b rdy=%b",
               nm, com_n, bcd, bi_n, frame_tick, wr_ready);
    end
  endtask

  // Expected outputs for scanning cycle s of slot k with displayed value a.
  function automatic exp_t view(input logic [15:0] a, input int k, input int s,
                                input logic lz, input logic rdy, input string nm);
    exp_t e;
    logic [15:0] up;
    e.com = 4'b1111;
    e.bi  = 1'b0;
    e.bcd = a[k*4 +: 4];
    e.chk = (s >= DEAD);
    up    = a >> (4 * k);
    if (s >= DEAD) begin
      e.com = ~(4'b0001 << k);
      e.bi  = !(lz && (k != 0) && (up == 16'd0));
    end
    e.ft  = (k == 3) && (s == DIV - 1);
    e.rdy = rdy;
    e.nm  = $sformatf("%s k%0d s%0d", nm, k, s);
    return e;
  endfunction

  function automatic exp_t dark(input logic rdy, input logic chk0, input string nm);
    exp_t e;
    e.com = 4'b1111;
    e.bcd = 4'd0;
    e.chk = chk0;
    e.bi  = 1'b0;
    e.ft  = 1'b0;
    e.rdy = rdy;
    e.nm  = nm;
    return e;
  endfunction

  task automatic tick_raw(input exp_t e);
    q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n, input logic [15:0] act, input logic rdy);
    for (int i = 0; i < n; i++) begin
      tick_raw(view(act, tk, ts, lzb, rdy, phase));
      ts = ts + 1;
      if (ts == DIV) begin
        ts = 0;
        tk = (tk + 1) % 4;
      end
    end
  endtask

  initial begin
    Aclr = 1'b0; en = 1'b1; lzb = 1'b0; wr_valid = 1'b0; wr_data = 16'd0;
    repeat (2) @(posedge Clk);
    #1;
    check_reset("reset_state");
    tick_raw(dark(1'b1, 1'b1, "reset_hold"));
    Aclr = 1'b1;

    // Idle frame after reset: dark, then digit0..3 slots, tick in cycle 31.
    phase = "idle";
    ticks(32, 16'h0000, 1'b1);

    // Write 0x1234 during the digit1 slot; shown from the next frame.
    phase = "wr1234";
    ticks(11, 16'h0000, 1'b1);
    wr_valid = 1'b1; wr_data = 16'h1234;
    ticks(1, 16'h0000, 1'b1);
    wr_valid = 1'b0; wr_data = 16'hxxxx;
    ticks(20, 16'h0000, 1'b0);
    ticks(32, 16'h1234, 1'b1);

    // Backpressure: 0x5678 accepted, 0x9999 held until the shadow drains.
    phase = "bp";
    wr_valid = 1'b1; wr_data = 16'h5678;
    ticks(1, 16'h1234, 1'b1);
    wr_data = 16'h9999;
    ticks(31, 16'h1234, 1'b0);
    ticks(1, 16'h5678, 1'b1);
    wr_valid = 1'b0;
    ticks(31, 16'h5678, 1'b0);

    // 9999 frame; load 0x0040 for the blanking checks.
    phase = "show9999";
    wr_valid = 1'b1; wr_data = 16'h0040;
    ticks(1, 16'h9999, 1'b1);
    wr_valid = 1'b0;
    ticks(31, 16'h9999, 1'b0);

    phase = "lzb1";
    lzb = 1'b1;
    ticks(32, 16'h0040, 1'b1);
    phase = "lzb0";
    lzb = 1'b0;
    ticks(32, 16'h0040, 1'b1);

    // Enable drop at k=2 s=5 with 0x0905 pending in the shadow.
    phase = "endrop";
    wr_valid = 1'b1; wr_data = 16'h0905;
    ticks(1, 16'h0040, 1'b1);
    wr_valid = 1'b0;
    ticks(20, 16'h0040, 1'b0);
    en = 1'b0;
    ticks(1, 16'h0040, 1'b0);
    for (int i = 0; i < 3; i++) tick_raw(dark(1'b0, 1'b0, "en_low"));
    en = 1'b1; tk = 0; ts = 0;
    phase = "enback";
    ticks(32, 16'h0040, 1'b0);
    ticks(32, 16'h0905, 1'b1);

    // Async reset pulse in the digit2 slot with 0x7777 pending.
    phase = "arst";
    wr_valid = 1'b1; wr_data = 16'h7777;
    ticks(1, 16'h0905, 1'b1);
    wr_valid = 1'b0;
    ticks(18, 16'h0905, 1'b0);
    q.push_back(dark(1'b1, 1'b1, "arst_async"));
    #2 Aclr = 1'b0;
    #1 check_reset("arst_immediate");
    #3 Aclr = 1'b1;
    @(posedge Clk);
    #1;
    tk = 0; ts = 1;
    phase = "post_arst";
    ticks(31, 16'h0000, 1'b1);
    ticks(8, 16'h0000, 1'b1);

    repeat (2) @(posedge Clk);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
